// File: rtl/div_issue_ctrl.sv
`default_nettype none
// =============================================================================
// div_issue_ctrl : EX-side issue, stall and HI/LO commit for the iterative divider
// Revision: 1.0
// =============================================================================
module div_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_div_req,
    input  logic              ex_div_signed,
    input  logic [DATA_W-1:0] ex_rs,
    input  logic [DATA_W-1:0] ex_rt,
    input  logic              flush,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] hilo_wdata,
    output logic              stall_req,
    output logic              div_en,
    output logic              div_signed,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    input  logic [DATA_W-1:0] div_q,
    input  logic [DATA_W-1:0] div_r,
    input  logic              div_busy,
    input  logic              div_done,
    input  logic              div_ovf,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div0_pulse,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // Watchdog fires on the TIMEOUT-th WAIT cycle (counter starts at 0 in the first one)
    localparam logic [CNT_W-1:0] C_WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wd_cnt;
    logic             w_accept;
    logic             w_commit;
    logic             w_timeout;

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_commit  = 1'b0;
        w_timeout = 1'b0;
        stall_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ex_div_req && !flush) begin
                    w_accept  = 1'b1;
                    stall_req = 1'b1;
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                stall_req = 1'b1;
                w_next    = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                stall_req = 1'b1;
                // A result landing with the flush is simply dropped: divider is already idle
                if (flush) begin
                    w_next = div_done ? S_IDLE : S_DRAIN;
                end else if (div_done) begin
                    w_commit = 1'b1;
                    w_next   = S_DONE;
                end else if (r_wd_cnt == C_WD_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_DRAIN;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_DRAIN: begin
                stall_req = ex_div_req;
                if (!div_busy) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wd_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state != S_WAIT) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != C_WD_LAST) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_en     <= 1'b0;
            div_signed <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
        end else begin
            div_en <= w_accept;
            if (w_accept) begin
                div_a      <= ex_rs;
                div_b      <= ex_rt;
                div_signed <= ex_div_signed;
            end
        end
    end

    // The in-flight divide is younger than any MTHI/MTLO in WB, so it wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi         <= '0;
            lo         <= '0;
            div0_pulse <= 1'b0;
        end else begin
            div0_pulse <= w_commit && div_ovf;
            if (w_commit) begin
                hi <= div_r;
                lo <= div_q;
            end else begin
                if (mthi_we) begin
                    hi <= hilo_wdata;
                end
                if (mtlo_we) begin
                    lo <= hilo_wdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// =============================================================================
// tb_div_issue_ctrl : randomized self-checking bench with a behavioural divider
// Revision: 1.0
// =============================================================================
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_div_req = 1'b0;
    logic        ex_div_signed = 1'b0;
    logic [31:0] ex_rs = '0;
    logic [31:0] ex_rt = '0;
    logic        flush = 1'b0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] hilo_wdata = '0;
    logic        stall_req, div_en, div_signed, div0_pulse, timeout_err;
    logic [31:0] div_a, div_b, hi, lo;
    logic [31:0] stub_q, stub_r;
    logic        stub_busy, stub_done, stub_zero;
    logic        div_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int stub_lat = 1;
    bit stub_hang = 1'b0;
    int stub_cnt;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DATA_W(32), .TIMEOUT(40), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .ex_div_req(ex_div_req), .ex_div_signed(ex_div_signed),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
        .hilo_wdata(hilo_wdata), .stall_req(stall_req), .div_en(div_en), .div_signed(div_signed),
        .div_a(div_a), .div_b(div_b), .div_q(stub_q), .div_r(stub_r), .div_busy(stub_busy),
        .div_done(stub_done), .div_ovf(div_ovf), .hi(hi), .lo(lo), .div0_pulse(div0_pulse),
        .timeout_err(timeout_err)
    );

    // Architectural result: {remainder, quotient}; divide-by-zero yields q=all ones, r=0
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = 32'd0;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Behavioural divider: done arrives stub_lat cycles after the start pulse
    assign div_ovf = stub_done && stub_zero;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_busy <= 1'b0;
            stub_done <= 1'b0;
            stub_zero <= 1'b0;
            stub_cnt  <= 0;
            stub_q    <= '0;
            stub_r    <= '0;
        end else begin
            stub_done <= 1'b0;
            if (div_en) begin
                {stub_r, stub_q} <= ref_div(div_signed, div_a, div_b);
                stub_zero <= (div_b == 32'd0);
                if (stub_hang) begin
                    stub_busy <= 1'b1;
                    stub_cnt  <= 0;
                end else if (stub_lat <= 1) begin
                    stub_busy <= 1'b0;
                    stub_done <= 1'b1;
                end else begin
                    stub_busy <= 1'b1;
                    stub_cnt  <= stub_lat - 1;
                end
            end else if (stub_busy && !stub_hang) begin
                if (stub_cnt <= 1) begin
                    stub_busy <= 1'b0;
                    stub_done <= 1'b1;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    task automatic run_div(input string name, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input bit collide);
        int stalls = 0;
        int en_cnt = 0;
        int pulses = 0;
        bit done_seen = 1'b0;
        logic [63:0] exp;
        exp = ref_div(sg, a, b);
        stub_lat = lat;
        @(posedge clk); #1;
        ex_div_req = 1'b1; ex_div_signed = sg; ex_rs = a; ex_rt = b;
        hilo_wdata = 32'hAA;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (div_en) en_cnt++;
            if (div0_pulse) pulses++;
            if (!stall_req) begin
                done_seen = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
            mthi_we = collide && stub_done;
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        n_checks++;
        if (done_seen !== 1'b1) $display("FAIL %s done: got %0b expected 1", name, done_seen);
        else n_pass++;
        n_checks++;
        if (stalls !== 2 + lat) $display("FAIL %s stall cycles: got %0d expected %0d", name, stalls, 2 + lat);
        else n_pass++;
        n_checks++;
        if (en_cnt !== 1) $display("FAIL %s div_en cycles: got %0d expected 1", name, en_cnt);
        else n_pass++;
        n_checks++;
        if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL %s hi/lo: got %h/%h expected %h/%h", name, hi, lo, m_hi, m_lo);
        else n_pass++;
        n_checks++;
        if (pulses !== ((b == 32'd0) ? 1 : 0)) $display("FAIL %s div0_pulse: got %0d expected %0d", name, pulses, (b == 32'd0) ? 1 : 0);
        else n_pass++;
        n_checks++;
        if ({div_signed, div_a, div_b} !== {sg, a, b}) $display("FAIL %s operands: got %0b %h %h expected %0b %h %h", name, div_signed, div_a, div_b, sg, a, b);
        else n_pass++;
        @(posedge clk); #1;
        ex_div_req = 1'b0; mthi_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({div_en, stall_req} !== 2'b00) $display("FAIL %s after done en/stall: got %b expected 00", name, {div_en, stall_req});
        else n_pass++;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({hi, lo, div_a, div_b} !== 128'd0) $display("FAIL reset data: got %h %h %h %h expected 0", hi, lo, div_a, div_b);
        else n_pass++;
        n_checks++;
        if ({div_en, div_signed, div0_pulse, timeout_err, stall_req} !== 5'd0) $display("FAIL reset flags: got %b expected 00000", {div_en, div_signed, div0_pulse, timeout_err, stall_req});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 5, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 3, 1'b0);
        run_div("divu_3_10_fast", 1'b0, 32'd3, 32'd10, 1, 1'b0);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 4, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic sg;
        for (int i = 0; i < 10; i++) begin
            sg = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            run_div("random", sg, a, b, $urandom_range(1, 6), 1'b0);
        end
    endtask

    task automatic test_hilo_writes;
        run_div("commit_vs_mthi", 1'b0, 32'd47, 32'd7, 3, 1'b1);
        @(posedge clk); #1;
        mtlo_we = 1'b1; hilo_wdata = 32'hBB;
        @(posedge clk); #1;
        mtlo_we = 1'b0;
        m_lo = 32'hBB;
        @(negedge clk);
        n_checks++;
        if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL mtlo_idle: got %h/%h expected %h/%h", hi, lo, m_hi, m_lo);
        else n_pass++;
        mthi_we = 1'b1; mtlo_we = 1'b1; hilo_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        mthi_we = 1'b0; mtlo_we = 1'b0;
        m_hi = 32'h1234_5678; m_lo = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL mthi_mtlo_both: got %h/%h expected %h/%h", hi, lo, m_hi, m_lo);
        else n_pass++;
    endtask

    task automatic test_flush;
        int stalls = 0;
        int en_cnt = 0;
        int held_bad = 0;
        bit done_seen = 1'b0;
        @(posedge clk); #1;
        ex_div_req = 1'b1; flush = 1'b1; ex_rs = 32'd9; ex_rt = 32'd2;
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b0) $display("FAIL flushed_req stall: got %b expected 0", stall_req);
        else n_pass++;
        @(posedge clk); #1;
        ex_div_req = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (div_en !== 1'b0) $display("FAIL flushed_req div_en: got %b expected 0", div_en);
        else n_pass++;
        stub_lat = 8;
        @(posedge clk); #1;
        ex_div_req = 1'b1; ex_div_signed = 1'b1; ex_rs = 32'h7FFF_FFFF; ex_rt = 32'd3;
        repeat (3) begin
            @(posedge clk); #1;
        end
        ex_div_req = 1'b0; flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b1) $display("FAIL flush_wait stall: got %b expected 1", stall_req);
        else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0; stub_lat = 2;
        ex_div_req = 1'b1; ex_div_signed = 1'b0; ex_rs = 32'd40; ex_rt = 32'd4;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (div_en) en_cnt++;
            if (!stall_req) begin
                done_seen = 1'b1;
                break;
            end
            if ({hi, lo} !== {m_hi, m_lo}) held_bad++;
            stalls++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (held_bad !== 0) $display("FAIL drain_hilo_held: got %0d changed cycles expected 0", held_bad);
        else n_pass++;
        n_checks++;
        if (stalls !== 10 || !done_seen) $display("FAIL drain_stall: got %0d cycles expected 10", stalls);
        else n_pass++;
        n_checks++;
        if (en_cnt !== 1) $display("FAIL drain_reissue div_en: got %0d expected 1", en_cnt);
        else n_pass++;
        m_hi = 32'd0; m_lo = 32'd10;
        n_checks++;
        if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL drain_then_divu: got %h/%h expected %h/%h", hi, lo, m_hi, m_lo);
        else n_pass++;
        @(posedge clk); #1;
        ex_div_req = 1'b0;
    endtask

    task automatic test_timeout;
        stub_hang = 1'b1;
        @(posedge clk); #1;
        ex_div_req = 1'b1; ex_div_signed = 1'b0; ex_rs = 32'd123; ex_rt = 32'd4;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            if (c == 41) begin
                n_checks++;
                if (timeout_err !== 1'b0) $display("FAIL timeout_early: got %b expected 0", timeout_err);
                else n_pass++;
            end
            if (c == 43) begin
                n_checks++;
                if ({timeout_err, stall_req} !== 2'b11) $display("FAIL timeout_set: got %b expected 11", {timeout_err, stall_req});
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        ex_div_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b0) $display("FAIL drain_no_req stall: got %b expected 0", stall_req);
        else n_pass++;
        stub_hang = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({hi, lo, timeout_err} !== {m_hi, m_lo, 1'b1}) $display("FAIL timeout_hilo: got %h/%h err %b expected %h/%h err 1", hi, lo, timeout_err, m_hi, m_lo);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        mthi_we = 1'b1; hilo_wdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        mthi_we = 1'b0;
        stub_hang = 1'b1;
        ex_div_req = 1'b1; ex_div_signed = 1'b1; ex_rs = 32'h55; ex_rt = 32'h66;
        repeat (6) @(posedge clk);
        @(negedge clk); #2;
        n_checks++;
        if ({stall_req, div_signed, hi} !== {1'b1, 1'b1, 32'hCAFE_0001}) $display("FAIL pre_reset: got %b %b %h expected 1 1 cafe0001", stall_req, div_signed, hi);
        else n_pass++;
        rst_n = 1'b0; ex_div_req = 1'b0;
        #1;
        n_checks++;
        if ({hi, lo, div_a, div_b} !== 128'd0) $display("FAIL async_reset data: got %h %h %h %h expected 0", hi, lo, div_a, div_b);
        else n_pass++;
        n_checks++;
        if ({div_en, div_signed, div0_pulse, timeout_err, stall_req} !== 5'd0) $display("FAIL async_reset flags: got %b expected 00000", {div_en, div_signed, div0_pulse, timeout_err, stall_req});
        else n_pass++;
        stub_hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        run_div("after_reset", 1'b0, 32'd40, 32'd4, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hilo_writes();
        test_flush();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
